// File: rtl/resource_lock_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// resource_lock_arbiter_pkg
//
// Shared types and helpers for the resource lock arbiter slice.
//   port_state_t  : per-port lock state (IDLE / WAIT / HOLD)
//   idx_width()   : index width for n entries, never less than 1 bit
//   id_is_older() : wrap-aware issue-ID age compare
// -----------------------------------------------------------------------------
package resource_lock_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } port_state_t;

    // Widest issue ID the age compare can handle.
    localparam int MAX_ID_WIDTH = 64;
    localparam int MAX_ID_IDX_W = $clog2(MAX_ID_WIDTH);

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // a is older than b when the top bit of (a - b), taken modulo 2^width, is
    // set. Operands arrive zero-extended; the low 'width' bits of the wide
    // difference equal the modulo-2^width difference, so only the bit
    // position needs to move with the configured width.
    function automatic logic id_is_older(input logic [MAX_ID_WIDTH-1:0] a,
                                         input logic [MAX_ID_WIDTH-1:0] b,
                                         input int width);
        logic [MAX_ID_WIDTH-1:0] diff;
        diff = a - b;
        return diff[MAX_ID_IDX_W'(width - 1)];
    endfunction

endpackage

// File: rtl/resource_lock_arbiter_free_unit_picker.sv
// -----------------------------------------------------------------------------
// free_unit_picker
//
// Combinational helper: returns the NUM_PICKS lowest set bit positions of a
// free-unit bitmap, lowest first.
//   free_mask : one bit per unit, 1 = unit may be granted this cycle
//   pick_idx  : pick_idx[k] is the k-th lowest free unit index
//   pick_vld  : pick_vld[k] is set when at least k+1 units are free
// -----------------------------------------------------------------------------
module free_unit_picker #(
    parameter int NUM_UNITS = 8,
    parameter int NUM_PICKS = 8,
    parameter int IDX_W     = 3
) (
    input  logic [NUM_UNITS-1:0]            free_mask,
    output logic [NUM_PICKS-1:0][IDX_W-1:0] pick_idx,
    output logic [NUM_PICKS-1:0]            pick_vld
);

    // Walk the units upward and drop each free one into the next empty slot.
    always_comb begin
        int count;
        count    = 0;
        pick_idx = '0;
        pick_vld = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (free_mask[u] && (count < NUM_PICKS)) begin
                pick_idx[count] = IDX_W'(u);
                pick_vld[count] = 1'b1;
                count           = count + 1;
            end
        end
    end

endmodule

// File: rtl/resource_lock_arbiter.sv
// -----------------------------------------------------------------------------
// resource_lock_arbiter
//
// Lends NUM_RES identical units (ALUs) to NUM_PORTS requesters. A port holds
// its unit for as long as it keeps req_valid high; there is no preemption.
// Each edge, up to as many requests as there are units free at the start of
// the cycle are granted, winners bound to free units in ascending unit order.
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   req_valid  : per-port level request / lock hold
//   req_id     : per-port issue ID (only used for oldest-first priority)
//   flush      : drops every lock; nothing is granted on a flush edge
//   grant      : per-port lock held (registered)
//   grant_res  : unit bound to each port, meaningful only while grant is set
//   res_busy   : per-unit locked flag
//
// Build option:
//   ARB_OLDEST_FIRST_EN : priority is oldest issue ID first (wrap-aware, ties
//                         to the lower port). Undefined: round-robin starting
//                         at rr_ptr and req_id is ignored.
// -----------------------------------------------------------------------------
module resource_lock_arbiter
    import resource_lock_arbiter_pkg::*;
#(
    parameter  int NUM_PORTS = 8,
    parameter  int NUM_RES   = 8,
    parameter  int ID_WIDTH  = 16,
    localparam int RES_W     = idx_width(NUM_RES)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_PORTS-1:0]               req_valid,
    input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] req_id,
    input  logic                               flush,
    output logic [NUM_PORTS-1:0]               grant,
    output logic [NUM_PORTS-1:0][RES_W-1:0]    grant_res,
    output logic [NUM_RES-1:0]                 res_busy
);

    localparam int PTR_W = idx_width(NUM_PORTS);

    port_state_t                   state_q [NUM_PORTS];
    port_state_t                   state_d [NUM_PORTS];
    logic [NUM_PORTS-1:0][RES_W-1:0] bound_q;
    logic [NUM_PORTS-1:0][RES_W-1:0] bound_d;
    logic [PTR_W-1:0]              rr_ptr;
    logic [PTR_W-1:0]              rr_ptr_nxt;

    logic [NUM_PORTS-1:0]          eligible;
    logic [NUM_PORTS-1:0]          remaining;
    logic [NUM_PORTS-1:0]          win;
    logic [NUM_PORTS-1:0][RES_W-1:0] win_unit;
    logic [NUM_RES-1:0][RES_W-1:0] pick_idx;
    logic [NUM_RES-1:0]            pick_vld;
    logic                          found;
    int                            best;
    int                            idx;

`ifndef ARB_OLDEST_FIRST_EN
    logic unused_req_id;
    assign unused_req_id = ^req_id;
`endif

    // Only units already free before this edge are offered, so a unit that a
    // holder releases on this edge cannot be re-granted until the next one.
    free_unit_picker #(
        .NUM_UNITS (NUM_RES),
        .NUM_PICKS (NUM_RES),
        .IDX_W     (RES_W)
    ) u_picker (
        .free_mask (~res_busy),
        .pick_idx  (pick_idx),
        .pick_vld  (pick_vld)
    );

    // A port competes whenever it requests and does not already hold a unit;
    // an IDLE port with req_valid high can win on the very next edge.
    always_comb begin
        eligible = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            eligible[p] = req_valid[p] && (state_q[p] != HOLD);
        end
    end

    // Arbitration: pick winners one at a time in priority order, the k-th
    // winner taking the k-th lowest free unit. Selecting sequentially keeps
    // every unit bound to a single port even if the wrap-aware age compare is
    // not transitive across the whole ID space.
    always_comb begin
        remaining  = eligible;
        win        = '0;
        win_unit   = '0;
        rr_ptr_nxt = rr_ptr;
        found      = 1'b0;
        best       = 0;
        idx        = 0;
        for (int k = 0; k < NUM_RES; k++) begin
            found = 1'b0;
            best  = 0;
            for (int o = 0; o < NUM_PORTS; o++) begin
`ifdef ARB_OLDEST_FIRST_EN
                idx = o;
`else
                idx = (int'(rr_ptr) + o) % NUM_PORTS;
`endif
                if (remaining[idx]) begin
                    if (!found) begin
                        found = 1'b1;
                        best  = idx;
                    end
`ifdef ARB_OLDEST_FIRST_EN
                    // Strictly older only, so equal ages keep the lower port.
                    else if (id_is_older(MAX_ID_WIDTH'(req_id[idx]),
                                         MAX_ID_WIDTH'(req_id[best]),
                                         ID_WIDTH)) begin
                        best = idx;
                    end
`endif
                end
            end
            if (found && pick_vld[k]) begin
                win[best]       = 1'b1;
                remaining[best] = 1'b0;
                win_unit[best]  = pick_idx[k];
`ifndef ARB_OLDEST_FIRST_EN
                // Later winners overwrite, leaving one past the last winner.
                rr_ptr_nxt = PTR_W'((best + 1) % NUM_PORTS);
`endif
            end
        end
        if (flush) begin
            win        = '0;
            rr_ptr_nxt = rr_ptr;
        end
    end

    // State register: reset discards every lock with no release handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '{default: IDLE};
            bound_q <= '0;
            rr_ptr  <= '0;
        end else begin
            state_q <= state_d;
            bound_q <= bound_d;
            rr_ptr  <= rr_ptr_nxt;
        end
    end

    // Next-state logic per port.
    always_comb begin
        state_d = state_q;
        bound_d = bound_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (flush) begin
                state_d[p] = IDLE;
                bound_d[p] = '0;
            end else begin
                case (state_q[p])
                    IDLE, WAIT: begin
                        if (!req_valid[p]) begin
                            state_d[p] = IDLE;
                        end else if (win[p]) begin
                            state_d[p] = HOLD;
                            bound_d[p] = win_unit[p];
                        end else begin
                            state_d[p] = WAIT;
                        end
                    end
                    HOLD: begin
                        if (!req_valid[p]) begin
                            state_d[p] = IDLE;
                        end
                    end
                    default: state_d[p] = IDLE;
                endcase
            end
        end
    end

    // Outputs decode registered state only, so they change on edges alone.
    always_comb begin
        logic holding;
        grant    = '0;
        res_busy = '0;
        holding  = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            holding  = (state_q[p] == HOLD);
            grant[p] = holding;
            for (int u = 0; u < NUM_RES; u++) begin
                if (holding && (bound_q[p] == RES_W'(u))) begin
                    res_busy[u] = 1'b1;
                end
            end
        end
    end

    assign grant_res = bound_q;

endmodule

// File: tb/tb_resource_lock_arbiter.sv
// -----------------------------------------------------------------------------
// tb_resource_lock_arbiter
//
// Directed bench for resource_lock_arbiter. Instance A uses 8 ports / 8 units,
// instance B uses 8 ports / 2 units so that units run out.
// -----------------------------------------------------------------------------
module tb_resource_lock_arbiter;

    localparam int NP   = 8;
    localparam int NR_A = 8;
    localparam int NR_B = 2;
    localparam int IDW  = 16;

    logic                    clk;
    logic                    rst_n;
    logic                    flush;
    logic [NP-1:0]           req_valid_a;
    logic [NP-1:0]           req_valid_b;
    logic [NP-1:0][IDW-1:0]  req_id_a;
    logic [NP-1:0][IDW-1:0]  req_id_b;
    logic [NP-1:0]           grant_a;
    logic [NP-1:0]           grant_b;
    logic [NP-1:0][2:0]      grant_res_a;
    logic [NP-1:0][0:0]      grant_res_b;
    logic [NR_A-1:0]         res_busy_a;
    logic [NR_B-1:0]         res_busy_b;

    int vectors;
    int miscompares;

    logic [NP-1:0]   prev_grant;
    logic [NP-1:0]   next_req;
    logic [NP-1:0]   waiting;
    logic            free_before;
    logic [NR_B-1:0] unit_mask;
    int              wait_cnt [NP];
    int              max_wait;

    resource_lock_arbiter #(
        .NUM_PORTS (NP),
        .NUM_RES   (NR_A),
        .ID_WIDTH  (IDW)
    ) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid_a),
        .req_id    (req_id_a),
        .flush     (flush),
        .grant     (grant_a),
        .grant_res (grant_res_a),
        .res_busy  (res_busy_a)
    );

    resource_lock_arbiter #(
        .NUM_PORTS (NP),
        .NUM_RES   (NR_B),
        .ID_WIDTH  (IDW)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid_b),
        .req_id    (req_id_b),
        .flush     (flush),
        .grant     (grant_b),
        .grant_res (grant_res_b),
        .res_busy  (res_busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [NP-1:0] req_a,
                                 input logic [NP-1:0] req_b,
                                 input logic          fl);
        req_valid_a = req_a;
        req_valid_b = req_b;
        flush       = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string       tag,
                               input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_id_a    = '0;
        req_id_b    = '0;
        applyStimulus('0, '0, 1'b0);

        // Reset state.
        tick();
        tick();
        checkOutput("reset_grant_a",     64'(grant_a),     64'h0);
        checkOutput("reset_busy_a",      64'(res_busy_a),  64'h0);
        checkOutput("reset_grant_res_a", 64'(grant_res_a), 64'h0);
        checkOutput("reset_grant_b",     64'(grant_b),     64'h0);
        rst_n = 1'b1;
        tick();

        // Single port 3 takes a unit one edge after asking and keeps it.
        $display("[TB] single requester");
        applyStimulus(8'h08, 8'h00, 1'b0);
        tick();
        checkOutput("single_grant",     64'(grant_a),        64'h08);
        checkOutput("single_grant_res", 64'(grant_res_a[3]), 64'h0);
        checkOutput("single_busy",      64'(res_busy_a),     64'h01);
        tick();
        tick();
        tick();
        checkOutput("single_hold",      64'(grant_a),        64'h08);
        applyStimulus(8'h00, 8'h00, 1'b0);
        tick();
        checkOutput("single_release",   64'(grant_a),        64'h00);
        checkOutput("single_rel_busy",  64'(res_busy_a),     64'h00);

        // Four holders on A (rr_ptr now 4, so ports 0..3 map to units 0..3).
        $display("[TB] flush");
        applyStimulus(8'h0F, 8'h00, 1'b0);
        tick();
        checkOutput("four_grant",       64'(grant_a),        64'h0F);
        checkOutput("four_busy",        64'(res_busy_a),     64'h0F);
        checkOutput("four_res1",        64'(grant_res_a[1]), 64'h1);
        checkOutput("four_res3",        64'(grant_res_a[3]), 64'h3);
        applyStimulus(8'h0F, 8'h00, 1'b1);
        tick();
        checkOutput("flush_grant",      64'(grant_a),        64'h00);
        checkOutput("flush_busy",       64'(res_busy_a),     64'h00);
        applyStimulus(8'h0F, 8'h00, 1'b0);
        tick();
        checkOutput("reflush_grant",    64'(grant_a),        64'h0F);
        checkOutput("reflush_busy",     64'(res_busy_a),     64'h0F);
        checkOutput("reflush_res2",     64'(grant_res_a[2]), 64'h2);

        // Port 0 drops for one cycle, then asks again and gets unit 0 back.
        $display("[TB] release and re-request");
        applyStimulus(8'h0E, 8'h00, 1'b0);
        tick();
        checkOutput("drop_grant",       64'(grant_a),        64'h0E);
        checkOutput("drop_busy",        64'(res_busy_a),     64'h0E);
        applyStimulus(8'h0F, 8'h00, 1'b0);
        tick();
        checkOutput("reraise_grant",    64'(grant_a),        64'h0F);
        checkOutput("reraise_res0",     64'(grant_res_a[0]), 64'h0);

        // All eight hold, then reset drops mid-cycle with no clock edge.
        $display("[TB] asynchronous reset while holding");
        applyStimulus(8'hFF, 8'h00, 1'b0);
        tick();
        checkOutput("all_grant",        64'(grant_a),        64'hFF);
        checkOutput("all_busy",         64'(res_busy_a),     64'hFF);
        checkOutput("all_res4",         64'(grant_res_a[4]), 64'h4);
        checkOutput("all_res7",         64'(grant_res_a[7]), 64'h7);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_grant",  64'(grant_a),        64'h00);
        checkOutput("async_rst_busy",   64'(res_busy_a),     64'h00);
        checkOutput("async_rst_res",    64'(grant_res_a),    64'h0);
        applyStimulus('0, '0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Two units, four requesters: ports 0,1 win; unit 0 freed by port 0
        // is not re-granted on its release edge, only on the next one.
        $display("[TB] two units, four requesters");
        applyStimulus(8'h00, 8'h0F, 1'b0);
        tick();
        checkOutput("rr_c1_grant",      64'(grant_b),        64'h03);
        checkOutput("rr_c1_res0",       64'(grant_res_b[0]), 64'h0);
        checkOutput("rr_c1_res1",       64'(grant_res_b[1]), 64'h1);
        checkOutput("rr_c1_busy",       64'(res_busy_b),     64'h3);
        tick();
        tick();
        applyStimulus(8'h00, 8'h0E, 1'b0);
        tick();
        checkOutput("rr_c4_grant",      64'(grant_b),        64'h02);
        checkOutput("rr_c4_busy",       64'(res_busy_b),     64'h2);
        tick();
        checkOutput("rr_c5_grant",      64'(grant_b),        64'h06);
        checkOutput("rr_c5_res2",       64'(grant_res_b[2]), 64'h0);
        applyStimulus(8'h00, 8'h0C, 1'b0);
        tick();
        checkOutput("rr_c6_grant",      64'(grant_b),        64'h04);
        checkOutput("rr_c6_busy",       64'(res_busy_b),     64'h1);
        tick();
        checkOutput("rr_c7_grant",      64'(grant_b),        64'h0C);
        checkOutput("rr_c7_res3",       64'(grant_res_b[3]), 64'h1);
        applyStimulus(8'h00, 8'h00, 1'b0);
        tick();
        checkOutput("rr_c8_grant",      64'(grant_b),        64'h00);

`ifdef ARB_OLDEST_FIRST_EN
        // 0xFFFE is older than 0x0001, which is older than 0x0003.
        $display("[TB] oldest first");
        req_id_b[0] = 16'h0003;
        req_id_b[1] = 16'hFFFE;
        req_id_b[2] = 16'h0001;
        applyStimulus(8'h00, 8'h07, 1'b0);
        tick();
        checkOutput("age_grant",        64'(grant_b),        64'h06);
        checkOutput("age_res1",         64'(grant_res_b[1]), 64'h0);
        checkOutput("age_res2",         64'(grant_res_b[2]), 64'h1);
`else
        // rr_ptr sits at 4, so ports 5 and 6 beat port 0.
        $display("[TB] round-robin pointer");
        applyStimulus(8'h00, 8'h61, 1'b0);
        tick();
        checkOutput("rrptr_grant",      64'(grant_b),        64'h60);
        checkOutput("rrptr_res5",       64'(grant_res_b[5]), 64'h0);
        checkOutput("rrptr_res6",       64'(grant_res_b[6]), 64'h1);
`endif
        applyStimulus(8'h00, 8'h00, 1'b0);
        req_id_b = '0;
        tick();
        tick();

        // Random traffic on B: waiting ports keep asking, holders sometimes
        // release, idle ports sometimes ask.
        $display("[TB] random traffic");
        for (int p = 0; p < NP; p++) wait_cnt[p] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            prev_grant = grant_b;
            for (int p = 0; p < NP; p++) begin
                if (req_valid_b[p] && grant_b[p]) next_req[p] = ($urandom_range(0, 3) != 0);
                else if (req_valid_b[p])          next_req[p] = 1'b1;
                else                              next_req[p] = ($urandom_range(0, 1) == 1);
            end
            free_before = ($countones(res_busy_b) < NR_B);
            waiting     = next_req & ~grant_b;
            applyStimulus(8'h00, next_req, 1'b0);
            tick();
            unit_mask = '0;
            for (int p = 0; p < NP; p++) begin
                if (grant_b[p]) unit_mask[grant_res_b[p]] = 1'b1;
            end
            checkOutput("inv_busy_count",  64'($countones(res_busy_b)), 64'($countones(grant_b)));
            checkOutput("inv_grant_limit", 64'($countones(grant_b) <= NR_B), 64'h1);
            checkOutput("inv_unit_unique", 64'($countones(unit_mask)), 64'($countones(grant_b)));
            checkOutput("inv_grant_req",   64'(grant_b & ~next_req), 64'h0);
            checkOutput("inv_no_preempt",  64'(prev_grant & next_req & ~grant_b), 64'h0);
`ifndef ARB_OLDEST_FIRST_EN
            max_wait = 0;
            for (int p = 0; p < NP; p++) begin
                if (waiting[p] && !grant_b[p]) begin
                    if (free_before) wait_cnt[p] = wait_cnt[p] + 1;
                end else begin
                    wait_cnt[p] = 0;
                end
                if (wait_cnt[p] > max_wait) max_wait = wait_cnt[p];
            end
            checkOutput("starve_bound", 64'(max_wait < NP), 64'h1);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
